// File: rtl/mips_prog_loader.sv
// Boot-time program loader: receives a framed byte stream, assembles
// big-endian 32-bit words, writes them from address 0 upward and, once the
// trailing XOR checksum matches, releases the MIPS core with a start pulse.
module mips_prog_loader #(
    parameter int          ADDR_W    = 10,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              cpu_start,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CNT_HI = 3'd1;
    localparam logic [2:0] S_CNT_LO = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CHK    = 3'd4;
    localparam logic [2:0] S_START  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    // Largest legal word count: the whole memory.
    localparam logic [16:0] MAX_CNT = 17'd1 << ADDR_W;

    logic [2:0]      state, next_state;
    logic [7:0]      cnt_hi;
    logic [15:0]     count;
    logic [1:0]      byte_idx;
    logic [ADDR_W:0] word_idx;
    logic [ADDR_W:0] word_next;
    logic [23:0]     shift;
    logic [7:0]      chk;
    logic            accept;
    logic [15:0]     cnt_full;
    logic            is_sync;
    logic            last_word;

    assign accept    = in_valid & in_ready;
    assign cnt_full  = {cnt_hi, in_byte};
    assign is_sync   = (in_byte == SYNC_BYTE);
    assign word_next = word_idx + 1'b1;
    assign last_word = (word_next == count[ADDR_W:0]);

    // Processor control and status decode straight from the state; during
    // reset the state is IDLE, which yields the held/idle values.
    assign cpu_start = (state == S_START);
    assign cpu_hold  = !((state == S_START) || (state == S_DONE));
    assign done      = (state == S_DONE);
    assign err       = (state == S_ERR);

    // Frame-parsing next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (accept && is_sync) next_state = S_CNT_HI;
            S_CNT_HI: if (accept) next_state = S_CNT_LO;
            S_CNT_LO: if (accept) begin
                          if ({1'b0, cnt_full} > MAX_CNT) next_state = S_ERR;
                          else if (cnt_full == 16'd0)     next_state = S_CHK;
                          else                            next_state = S_DATA;
                      end
            S_DATA:   if (accept && byte_idx == 2'd3 && last_word) next_state = S_CHK;
            S_CHK:    if (accept) next_state = (in_byte == chk) ? S_START : S_ERR;
            S_START:  next_state = S_DONE;
            S_DONE:   next_state = S_DONE;
            S_ERR:    if (accept && is_sync) next_state = S_CNT_HI;
            default:  next_state = S_IDLE;
        endcase
    end

    // State register; in_ready is registered so it rises one edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
        end else begin
            state    <= next_state;
            in_ready <= !((next_state == S_START) || (next_state == S_DONE));
        end
    end

    // Datapath: count capture, word assembly, checksum and memory write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_hi       <= '0;
            count        <= '0;
            byte_idx     <= '0;
            word_idx     <= '0;
            shift        <= '0;
            chk          <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            words_loaded <= '0;
        end else begin
            mem_we <= 1'b0;
            if (accept) begin
                case (state)
                    S_IDLE, S_ERR: if (is_sync) words_loaded <= '0;
                    S_CNT_HI: cnt_hi <= in_byte;
                    S_CNT_LO: begin
                        count    <= cnt_full;
                        byte_idx <= '0;
                        word_idx <= '0;
                        chk      <= '0;
                    end
                    S_DATA: begin
                        chk      <= chk ^ in_byte;
                        shift    <= {shift[15:0], in_byte};
                        byte_idx <= byte_idx + 1'b1;
                        if (byte_idx == 2'd3) begin
                            mem_we       <= 1'b1;
                            mem_addr     <= word_idx[ADDR_W-1:0];
                            mem_wdata    <= {shift, in_byte};
                            words_loaded <= words_loaded + 1'b1;
                            word_idx     <= word_next;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Directed bench for mips_prog_loader: frames are driven byte by byte and
// memory writes / start pulses are captured by a negedge monitor.
module tb_mips_prog_loader;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        in_byte = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              cpu_start;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    int checks = 0;
    int errors = 0;

    logic [31:0] prog [0:1023];
    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    logic [31:0] wr_wl_q   [$];
    int          start_cnt = 0;
    logic        hold_at_start = 1'b1;

    mips_prog_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_valid(in_valid),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .cpu_start(cpu_start),
        .done(done), .err(err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // Capture every memory write and start pulse, once per cycle.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            wr_addr_q.push_back(32'(mem_addr));
            wr_data_q.push_back(mem_wdata);
            wr_wl_q.push_back(32'(words_loaded));
        end
        if (rst_n && cpu_start) begin
            start_cnt     = start_cnt + 1;
            hold_at_start = cpu_hold;
        end
    end

    task automatic clr_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_wl_q.delete();
        start_cnt     = 0;
        hold_at_start = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clr_mon();
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        in_byte  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            errors++;
            $display("FAIL send_byte timeout: in_ready=%0b required 1 for byte %h", in_ready, b);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic gap(input int maxgap);
        int g;
        g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
        repeat (g) @(negedge clk);
    endtask

    // Count, data words from prog[] and checksum (optionally corrupted).
    task automatic send_body(input int n, input logic [7:0] chk_flip, input int maxgap);
        logic [7:0] c;
        logic [31:0] w;
        c = 8'h00;
        send_byte(8'(n >> 8));
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            w = prog[i];
            for (int k = 3; k >= 0; k--) begin
                gap(maxgap);
                send_byte(w[k*8 +: 8]);
                c = c ^ w[k*8 +: 8];
            end
        end
        send_byte(c ^ chk_flip);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, cpu_start, done, err, words_loaded}
            !== {1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0}) begin
            errors++;
            $display("FAIL reset_values: rdy=%b we=%b addr=%h wd=%h hold=%b st=%b dn=%b er=%b wl=%0d",
                     in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, cpu_start, done, err, words_loaded);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clr_mon();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b required 1", in_ready);
        end
    endtask

    task automatic test_single_word();
        logic [7:0] fr [8];
        fr = '{8'hA5, 8'h00, 8'h01, 8'h28, 8'h0A, 8'h00, 8'hC8, 8'hEA};
        do_reset();
        foreach (fr[i]) send_byte(fr[i]);
        repeat (3) @(negedge clk);
        checks++;
        if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 32'd0 || wr_data_q[0] !== 32'h280a00c8) begin
            errors++;
            $display("FAIL single_write: n=%0d addr=%0d data=%h required 1/0/280a00c8",
                     wr_addr_q.size(), (wr_addr_q.size() > 0) ? wr_addr_q[0] : 32'hx,
                     (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hx);
        end
        checks++;
        if (wr_wl_q.size() != 1 || wr_wl_q[0] !== 32'd1) begin
            errors++;
            $display("FAIL single_wl_with_we: got %0d required 1", (wr_wl_q.size() > 0) ? wr_wl_q[0] : 32'hx);
        end
        checks++;
        if (start_cnt != 1 || hold_at_start !== 1'b0) begin
            errors++;
            $display("FAIL single_start: pulses=%0d hold=%b required 1/0", start_cnt, hold_at_start);
        end
        checks++;
        if ({cpu_hold, cpu_start, done, err, in_ready} !== 5'b00100 || words_loaded !== 11'd1) begin
            errors++;
            $display("FAIL single_final: hold=%b st=%b dn=%b er=%b rdy=%b wl=%0d required 0 0 1 0 0 1",
                     cpu_hold, cpu_start, done, err, in_ready, words_loaded);
        end
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== 10'd0 || mem_wdata !== 32'h280a00c8) begin
            errors++;
            $display("FAIL single_hold_bus: we=%b addr=%0d data=%h required 0/0/280a00c8", mem_we, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_program();
        int bad;
        logic [31:0] p [11];
        p = '{32'h280a00c8, 32'h20080000, 32'h20090001, 32'h01094020, 32'h21290001, 32'h152afffd,
              32'h00000000, 32'hac080000, 32'h8c0c0000, 32'h08000009, 32'hfc000000};
        do_reset();
        foreach (p[i]) prog[i] = p[i];
        send_byte(8'hA5);
        send_body(11, 8'h00, 3);
        repeat (3) @(negedge clk);
        bad = 0;
        for (int i = 0; i < wr_addr_q.size(); i++)
            if (wr_addr_q[i] !== 32'(i) || wr_data_q[i] !== p[i]) bad++;
        checks++;
        if (wr_addr_q.size() != 11 || bad != 0) begin
            errors++;
            $display("FAIL program_writes: n=%0d bad=%0d required 11/0", wr_addr_q.size(), bad);
        end
        checks++;
        if (done !== 1'b1 || words_loaded !== 11'd11 || start_cnt != 1) begin
            errors++;
            $display("FAIL program_final: done=%b wl=%0d pulses=%0d required 1/11/1", done, words_loaded, start_cnt);
        end
    endtask

    task automatic test_bad_chk();
        do_reset();
        prog[0] = 32'h280a00c8;
        send_byte(8'hA5);
        send_body(1, 8'h01, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 32'd0) begin
            errors++;
            $display("FAIL badchk_write: n=%0d required 1 at addr 0", wr_addr_q.size());
        end
        checks++;
        if ({err, cpu_hold, in_ready, done} !== 4'b1110 || start_cnt != 0) begin
            errors++;
            $display("FAIL badchk_err: err=%b hold=%b rdy=%b done=%b pulses=%0d required 1 1 1 0 0",
                     err, cpu_hold, in_ready, done, start_cnt);
        end
        send_byte(8'hA5);
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || words_loaded !== 11'd0) begin
            errors++;
            $display("FAIL retry_clear: err=%b wl=%0d required 0/0", err, words_loaded);
        end
        prog[0] = 32'h12345678;
        send_body(1, 8'h00, 1);
        repeat (3) @(negedge clk);
        checks++;
        if (done !== 1'b1 || start_cnt != 1 || wr_data_q.size() != 2 || wr_data_q[1] !== 32'h12345678) begin
            errors++;
            $display("FAIL retry_done: done=%b pulses=%0d writes=%0d required 1/1/2", done, start_cnt, wr_data_q.size());
        end
    endtask

    task automatic test_oversize();
        int bad;
        do_reset();
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'h01);
        repeat (2) @(negedge clk);
        checks++;
        if (err !== 1'b1 || wr_addr_q.size() != 0) begin
            errors++;
            $display("FAIL oversize_err: err=%b writes=%0d required 1/0", err, wr_addr_q.size());
        end
        for (int i = 0; i < 1024; i++) prog[i] = 32'h9E3779B9 * 32'(i + 1);
        send_byte(8'hA5);
        send_body(1024, 8'h00, 0);
        repeat (3) @(negedge clk);
        bad = 0;
        for (int i = 0; i < wr_addr_q.size(); i++)
            if (wr_addr_q[i] !== 32'(i) || wr_data_q[i] !== prog[i]) bad++;
        checks++;
        if (wr_addr_q.size() != 1024 || bad != 0) begin
            errors++;
            $display("FAIL max_writes: n=%0d bad=%0d required 1024/0", wr_addr_q.size(), bad);
        end
        checks++;
        if (done !== 1'b1 || words_loaded !== 11'd1024) begin
            errors++;
            $display("FAIL max_final: done=%b wl=%0d required 1/1024", done, words_loaded);
        end
    endtask

    task automatic test_noise_zero();
        logic [7:0] fr [7];
        fr = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h00, 8'h00, 8'h00};
        do_reset();
        foreach (fr[i]) send_byte(fr[i]);
        repeat (3) @(negedge clk);
        checks++;
        if (wr_addr_q.size() != 0 || start_cnt != 1 || done !== 1'b1 || words_loaded !== 11'd0) begin
            errors++;
            $display("FAIL noise_zero: writes=%0d pulses=%0d done=%b wl=%0d required 0/1/1/0",
                     wr_addr_q.size(), start_cnt, done, words_loaded);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'hDE);
        send_byte(8'hAD);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, cpu_start, done, err, words_loaded}
            !== {1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0}) begin
            errors++;
            $display("FAIL midreset_values: rdy=%b we=%b addr=%h wd=%h hold=%b dn=%b er=%b wl=%0d",
                     in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err, words_loaded);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clr_mon();
        prog[0] = 32'hCAFEF00D;
        prog[1] = 32'h0BADBEEF;
        send_byte(8'hA5);
        send_body(2, 8'h00, 2);
        repeat (3) @(negedge clk);
        checks++;
        if (wr_data_q.size() != 2 || wr_data_q[0] !== 32'hCAFEF00D || wr_data_q[1] !== 32'h0BADBEEF ||
            wr_addr_q[1] !== 32'd1 || done !== 1'b1 || words_loaded !== 11'd2) begin
            errors++;
            $display("FAIL midreset_reload: writes=%0d done=%b wl=%0d required 2/1/2",
                     wr_data_q.size(), done, words_loaded);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_program();
        test_bad_chk();
        test_oversize();
        test_noise_zero();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
